// File: rtl/fl_pkg.sv
// Shared binary32 definitions for the floating-point multiplier: format constants,
// field extraction helpers and operand classification.
package fl_pkg;

    localparam int          FP_BIAS  = 127;
    localparam int          EXP_W    = 8;
    localparam int          FRAC_W   = 23;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } op_class_e;

    function automatic logic get_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] get_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [FRAC_W-1:0] get_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

    // Denormals (exponent 0) classify as ZERO: the datapath flushes them.
    function automatic op_class_e classify(input logic [31:0] x);
        if (get_exp(x) == '0)
            return ZERO;
        else if (get_exp(x) == '1)
            return (get_frac(x) == '0) ? INF : NAN;
        else
            return NORM;
    endfunction

endpackage

// File: rtl/fl_mult_round.sv
// Normalises a 48-bit mantissa product, rounds to nearest-even and packs a binary32
// value, reporting exponent overflow/underflow after rounding.
module fl_mult_round
    import fl_pkg::*;
(
    input  logic               i_sign,
    input  logic [47:0]        i_product,
    input  logic signed [9:0]  i_exp,
    output logic [31:0]        o_value,
    output logic               o_overflow,
    output logic               o_underflow
);

    logic [FRAC_W-1:0]  w_frac_trunc;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [FRAC_W:0]    w_frac_rounded;
    logic signed [9:0]  w_exp_norm;
    logic signed [9:0]  w_exp_final;

    always_comb begin
        if (i_product[47]) begin
            w_frac_trunc = i_product[46:24];
            w_guard      = i_product[23];
            w_sticky     = |i_product[22:0];
            w_exp_norm   = i_exp + 10'sd1;
        end else begin
            w_frac_trunc = i_product[45:23];
            w_guard      = i_product[22];
            w_sticky     = |i_product[21:0];
            w_exp_norm   = i_exp;
        end
    end

    // A carry out of the fraction leaves the lower bits all zero, i.e. mantissa 1.0.
    assign w_round_up     = w_guard & (w_sticky | w_frac_trunc[0]);
    assign w_frac_rounded = {1'b0, w_frac_trunc} + {{FRAC_W{1'b0}}, w_round_up};
    assign w_exp_final    = w_exp_norm + (w_frac_rounded[FRAC_W] ? 10'sd1 : 10'sd0);

    assign o_overflow  = (w_exp_final >= 10'sd255);
    assign o_underflow = (w_exp_final <= 10'sd0);

    always_comb begin
        if (o_overflow)
            o_value = {i_sign, 8'hFF, 23'h0};
        else if (o_underflow)
            o_value = POS_ZERO;
        else
            o_value = {i_sign, w_exp_final[7:0], w_frac_rounded[FRAC_W-1:0]};
    end

endmodule

// File: rtl/fl_mult.sv
// Binary32 multiplier: combinational product with special-case handling and
// status flags registered on each rising clock edge.
module fl_mult
    import fl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic [31:0] result,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);

    op_class_e          w_class_a;
    op_class_e          w_class_b;
    logic               w_sign;
    logic [47:0]        w_mant_a;
    logic [47:0]        w_mant_b;
    logic [47:0]        w_product;
    logic signed [9:0]  w_exp_sum;
    logic [31:0]        w_round_value;
    logic               w_round_ovf;
    logic               w_round_unf;
    logic               w_any_nan;
    logic               w_any_inf;
    logic               w_any_zero;
    logic               w_exc_next;
    logic               w_ovf_next;
    logic               w_unf_next;
    logic               r_exception;
    logic               r_overflow;
    logic               r_underflow;

    assign w_class_a = classify(a_operand);
    assign w_class_b = classify(b_operand);
    assign w_sign    = get_sign(a_operand) ^ get_sign(b_operand);

    assign w_mant_a  = {24'd0, 1'b1, get_frac(a_operand)};
    assign w_mant_b  = {24'd0, 1'b1, get_frac(b_operand)};
    assign w_product = w_mant_a * w_mant_b;
    assign w_exp_sum = 10'(get_exp(a_operand)) + 10'(get_exp(b_operand)) - 10'(FP_BIAS);

    fl_mult_round u_round (
        .i_sign      (w_sign),
        .i_product   (w_product),
        .i_exp       (w_exp_sum),
        .o_value     (w_round_value),
        .o_overflow  (w_round_ovf),
        .o_underflow (w_round_unf)
    );

    assign w_any_nan  = (w_class_a == NAN)  || (w_class_b == NAN);
    assign w_any_inf  = (w_class_a == INF)  || (w_class_b == INF);
    assign w_any_zero = (w_class_a == ZERO) || (w_class_b == ZERO);

    // NOTE: every output gets a default first so no path through the priority chain infers a latch.
    always_comb begin
        result     = w_round_value;
        w_exc_next = 1'b0;
        w_ovf_next = 1'b0;
        w_unf_next = 1'b0;
        if (w_any_nan || (w_any_inf && w_any_zero)) begin
            result     = QNAN;
            w_exc_next = 1'b1;
        end else if (w_any_inf) begin
            result     = {w_sign, 8'hFF, 23'h0};
            w_exc_next = 1'b1;
        end else if (w_any_zero) begin
            result     = POS_ZERO;
        end else begin
            w_ovf_next = w_round_ovf;
            w_unf_next = w_round_unf;
        end
    end

    // NOTE: non-blocking assignments keep the flag update order-independent across processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exception <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_exception <= w_exc_next;
            r_overflow  <= w_ovf_next;
            r_underflow <= w_unf_next;
        end
    end

    assign exception = r_exception;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fl_mult.sv
// Self-checking bench for fl_mult: directed vector table, a real-arithmetic reference
// model for random operands, and an asynchronous mid-cycle reset sequence.
module tb_fl_mult;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [31:0] result;
    logic        exception;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    fl_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .result    (result),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        logic        ovf;
        logic        unf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact product of the real operand values, renormalised and rounded
    // to 24 significant bits with ties-to-even, then mapped onto the special cases.
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output logic exc,
                             output logic ovf, output logic unf);
        bit     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
        real    mag, scaled, fl, rem;
        int     e, biased;
        longint q;
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        sign   = a[31] ^ b[31];
        exc = 1'b0; ovf = 1'b0; unf = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = 32'h7FC0_0000; exc = 1'b1;
        end else if (a_inf || b_inf) begin
            res = {sign, 8'hFF, 23'h0}; exc = 1'b1;
        end else if (a_zero || b_zero) begin
            res = 32'h0;
        end else begin
            mag = real'(longint'({1'b1, a[22:0]})) * real'(longint'({1'b1, b[22:0]}));
            e   = int'(a[30:23]) - 127 + int'(b[30:23]) - 127 - 46;
            while (mag >= 2.0) begin mag = mag / 2.0; e++; end
            while (mag < 1.0)  begin mag = mag * 2.0; e--; end
            scaled = mag * 8388608.0;
            fl     = $floor(scaled);
            rem    = scaled - fl;
            q      = longint'(fl);
            if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
            if (q == 64'd16777216) begin q = 64'd8388608; e++; end
            biased = e + 127;
            if (biased >= 255) begin
                res = {sign, 8'hFF, 23'h0}; ovf = 1'b1;
            end else if (biased <= 0) begin
                res = 32'h0; unf = 1'b1;
            end else begin
                res = {sign, biased[7:0], q[22:0]};
            end
        end
    endtask

    task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic exc, input logic ovf,
                           input logic unf);
        @(negedge clk);
        a_operand = a;
        b_operand = b;
        #1 check({name, " result"}, result, res);
        @(posedge clk);
        #1 check({name, " flags"}, {29'd0, exception, overflow, underflow},
                 {29'd0, exc, ovf, unf});
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 11))
            0:       x[30:23] = 8'h00;
            1:       x[30:23] = 8'hFF;
            2:       begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
            3:       x[30:23] = 8'($urandom_range(1, 30));
            4:       x[30:23] = 8'($urandom_range(225, 254));
            5, 6:    x[30:23] = 8'($urandom_range(55, 72));
            default: ;
        endcase
        return x;
    endfunction

    vec_t vecs[16];

    initial begin
        logic [31:0] ra, rb, rres;
        logic        rexc, rovf, runf;

        vecs[0]  = '{"mul45x63",   32'h4234_851F, 32'h427C_851F, 32'h4532_10EA, 0, 0, 0};
        vecs[1]  = '{"neg_result", 32'h4049_999A, 32'hC166_3D71, 32'hC235_5063, 0, 0, 0};
        vecs[2]  = '{"neg_x_neg",  32'hC152_6666, 32'hC240_A3D7, 32'h441E_5374, 0, 0, 0};
        vecs[3]  = '{"zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0};
        vecs[4]  = '{"neg_x_zero", 32'hC152_6666, 32'h0000_0000, 32'h0000_0000, 0, 0, 0};
        vecs[5]  = '{"two_x_two",  32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0, 0, 0};
        vecs[6]  = '{"overflow",   32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 0, 1, 0};
        vecs[7]  = '{"underflow",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 0, 0, 1};
        vecs[8]  = '{"inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0, 0};
        vecs[9]  = '{"nan_x_one",  32'h7FA0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1, 0, 0};
        vecs[10] = '{"ninf_x_two", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1, 0, 0};
        vecs[11] = '{"inf_x_inf",  32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000, 1, 0, 0};
        vecs[12] = '{"denorm_ftz", 32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, 0};
        vecs[13] = '{"inf_x_den",  32'h7F80_0000, 32'h8000_1234, 32'h7FC0_0000, 1, 0, 0};
        vecs[14] = '{"tie_odd_up", 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 0, 0, 0};
        vecs[15] = '{"tie_even",   32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 0, 0, 0};

        // Reset held across a clock edge with exception-raising operands.
        rst_n     = 1'b0;
        a_operand = 32'h7F80_0000;
        b_operand = 32'h0000_0000;
        @(posedge clk);
        #1 check("reset flags", {29'd0, exception, overflow, underflow}, 32'd0);
        check("reset result", result, 32'h7FC0_0000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res,
                    vecs[i].exc, vecs[i].ovf, vecs[i].unf);

        for (int i = 0; i < 400; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            ref_model(ra, rb, rres, rexc, rovf, runf);
            run_vec($sformatf("rnd%0d a=%h b=%h", i, ra, rb), ra, rb, rres, rexc, rovf, runf);
        end

        // Asynchronous reset asserted mid-cycle must clear flags before the next edge.
        run_vec("pre_reset", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("async_reset flags", {29'd0, exception, overflow, underflow}, 32'd0);
        check("async_reset result", result, 32'h7FC0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_reset", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
